// File: rtl/btb_update_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl_pkg
// Shared definitions for the BTB write-side controller.
//   - Default BTB geometry (index width, address width, update queue depth).
//   - Controller state encoding (BTBU_CLEAR / BTBU_RUN).
//   - Width of one packed update entry {tag, target, taken}.
//   - Saturating 16-bit increment used by the optional perf counters.
// -----------------------------------------------------------------------------
package btb_update_ctrl_pkg;

    localparam int BTB_TAG_W      = 10;  // BTB index width, 2^BTB_TAG_W entries
    localparam int BTB_ADDR_W     = 32;  // instruction address width
    localparam int BTB_FIFO_DEPTH = 4;   // update queue depth (power of two, >= 2)

    typedef enum logic {
        BTBU_CLEAR = 1'b0,  // invalidation sweep over every BTB entry
        BTBU_RUN   = 1'b1   // draining resolved branch updates
    } btbu_state_e;

    // An update entry is packed as {tag, target, taken}.
    function automatic int upd_entry_w(input int tag_w, input int addr_w);
        return tag_w + addr_w + 1;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
        if (en && (val != 16'hFFFF)) begin
            return val + 16'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// -----------------------------------------------------------------------------
// btb_upd_fifo
// Synchronous FIFO holding branch-resolution updates until the BTB write port
// is free. Push and pop may occur in the same cycle (occupancy unchanged, also
// when full). flush discards the contents by clearing pointers and count.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low pointer/count reset
//   push, din   write din when not full (or when a pop frees a slot)
//   pop         retire the head entry when not empty
//   flush       empty the FIFO on the next edge (wins over push/pop)
//   dout        head entry (valid when !empty)
//   full, empty, count  occupancy status
// -----------------------------------------------------------------------------
module btb_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the same cycle pops the head.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops sample the
    // same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; entries are only read after being written,
    // so resetting the pointers is enough and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
// Write-side controller of the branch target buffer. Resolved branch updates
// from EX are queued in btb_upd_fifo and drained into the single BTB write
// port one per cycle. After reset and on flush_req the controller sweeps every
// BTB index with an invalidating write before updates are accepted again.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n         clock, asynchronous active-low reset
//   upd_valid/pc_tag/target/taken  resolved branch from EX
//   upd_ready                      update accepted when upd_valid is high
//   flush_req                      one-cycle pulse: invalidate the whole BTB
//   wr_req/clr/pc_tag/predicted_pc/jump_state  registered BTB write port
//   lookup_block                   fetch must treat BTB output as not-taken
//   sweep_busy                     invalidation sweep in progress
//
// Optional build macro BTB_UPD_PERF_EN adds saturating 16-bit counters:
//   perf_upd_cnt (update writes), perf_drop_cnt (upd_valid && !upd_ready
//   cycles), perf_flush_cnt (flush_req pulses). Cleared by reset only.
// -----------------------------------------------------------------------------
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int TAG_W      = BTB_TAG_W,
    parameter int ADDR_W     = BTB_ADDR_W,
    parameter int FIFO_DEPTH = BTB_FIFO_DEPTH
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              upd_valid,
    input  logic [TAG_W-1:0]  upd_pc_tag,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    output logic              upd_ready,
    input  logic              flush_req,
    output logic              wr_req,
    output logic              wr_clr,
    output logic [TAG_W-1:0]  wr_pc_tag,
    output logic [ADDR_W-1:0] wr_predicted_pc,
    output logic              wr_jump_state,
    output logic              lookup_block,
    output logic              sweep_busy
`ifdef BTB_UPD_PERF_EN
    ,
    output logic [15:0]       perf_upd_cnt,
    output logic [15:0]       perf_drop_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int ENTRY_W = upd_entry_w(TAG_W, ADDR_W);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    btbu_state_e       state_q, state_d;
    // One bit wider than the index: the carry into the MSB marks the last
    // sweep write.
    logic [TAG_W:0]    sweep_cnt_q, sweep_cnt_d, sweep_cnt_inc;

    logic              wr_req_q, wr_req_d;
    logic              wr_clr_q, wr_clr_d;
    logic [TAG_W-1:0]  wr_pc_tag_q, wr_pc_tag_d;
    logic [ADDR_W-1:0] wr_predicted_pc_q, wr_predicted_pc_d;
    logic              wr_jump_state_q, wr_jump_state_d;

    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_din, fifo_dout;
    // Occupancy is not needed here; full/empty carry all the control.
    logic [CNT_W-1:0]   fifo_count_unused;

    // ------------------------------------------------------------------
    // Update queue
    // ------------------------------------------------------------------
    assign upd_ready = (state_q == BTBU_RUN) && !fifo_full && !flush_req;
    assign fifo_push = upd_valid && upd_ready;
    assign fifo_din  = {upd_pc_tag, upd_target, upd_taken};

    btb_upd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // ------------------------------------------------------------------
    // Sweep / drain FSM and next write-port values
    // ------------------------------------------------------------------
    assign sweep_cnt_inc = sweep_cnt_q + (TAG_W+1)'(1);

    always_comb begin
        state_d           = state_q;
        sweep_cnt_d       = sweep_cnt_q;
        wr_req_d          = 1'b0;
        wr_clr_d          = 1'b0;
        wr_pc_tag_d       = '0;
        wr_predicted_pc_d = '0;
        wr_jump_state_d   = 1'b0;
        fifo_pop          = 1'b0;
        fifo_flush        = 1'b0;

        case (state_q)
            BTBU_CLEAR: begin
                wr_req_d    = 1'b1;
                wr_clr_d    = 1'b1;
                wr_pc_tag_d = sweep_cnt_q[TAG_W-1:0];
                if (flush_req) begin
                    // Restart the sweep; indices already cleared get cleared again.
                    sweep_cnt_d = '0;
                end else if (sweep_cnt_inc[TAG_W]) begin
                    sweep_cnt_d = '0;
                    state_d     = BTBU_RUN;
                end else begin
                    sweep_cnt_d = sweep_cnt_inc;
                end
            end
            BTBU_RUN: begin
                if (flush_req) begin
                    // Queued updates are stale; the sweep that follows
                    // overwrites anything already written this cycle.
                    fifo_flush  = 1'b1;
                    sweep_cnt_d = '0;
                    state_d     = BTBU_CLEAR;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_req_d = 1'b1;
                    {wr_pc_tag_d, wr_predicted_pc_d, wr_jump_state_d} = fifo_dout;
                end
            end
            default: begin
                state_d = BTBU_CLEAR;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q           <= BTBU_CLEAR;
            sweep_cnt_q       <= '0;
            wr_req_q          <= 1'b0;
            wr_clr_q          <= 1'b0;
            wr_pc_tag_q       <= '0;
            wr_predicted_pc_q <= '0;
            wr_jump_state_q   <= 1'b0;
        end else begin
            state_q           <= state_d;
            sweep_cnt_q       <= sweep_cnt_d;
            wr_req_q          <= wr_req_d;
            wr_clr_q          <= wr_clr_d;
            wr_pc_tag_q       <= wr_pc_tag_d;
            wr_predicted_pc_q <= wr_predicted_pc_d;
            wr_jump_state_q   <= wr_jump_state_d;
        end
    end

    assign wr_req          = wr_req_q;
    assign wr_clr          = wr_clr_q;
    assign wr_pc_tag       = wr_pc_tag_q;
    assign wr_predicted_pc = wr_predicted_pc_q;
    assign wr_jump_state   = wr_jump_state_q;

    // Predictions are unusable during the sweep and in the flush cycle itself.
    assign lookup_block = (state_q == BTBU_CLEAR) || flush_req;
    assign sweep_busy   = (state_q == BTBU_CLEAR);

`ifdef BTB_UPD_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (survive flush, cleared by reset)
    // ------------------------------------------------------------------
    logic [15:0] perf_upd_cnt_q,   perf_upd_cnt_d;
    logic [15:0] perf_drop_cnt_q,  perf_drop_cnt_d;
    logic [15:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_upd_cnt_d   = sat_inc16(perf_upd_cnt_q, wr_req_d && !wr_clr_d);
        perf_drop_cnt_d  = sat_inc16(perf_drop_cnt_q, upd_valid && !upd_ready);
        perf_flush_cnt_d = sat_inc16(perf_flush_cnt_q, flush_req);
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            perf_upd_cnt_q   <= '0;
            perf_drop_cnt_q  <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_upd_cnt_q   <= perf_upd_cnt_d;
            perf_drop_cnt_q  <= perf_drop_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_upd_cnt   = perf_upd_cnt_q;
    assign perf_drop_cnt  = perf_drop_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller for the branch target buffer (BTB).
- Buffers branch-resolution updates from EX in a small FIFO and drains them into the BTB's single write port, one per cycle.
- Owns a sweep FSM that invalidates every BTB entry after reset and on flush requests, such as fence.i or an ASID change.
- Tells the fetch stage when BTB predictions must be ignored.

Parameters:
- TAG_W, 10: BTB index width; the BTB has 2^TAG_W entries.
- ADDR_W, 32: instruction address width.
- FIFO_DEPTH, 4: update queue depth; power of two, at least 2.

Ports:
- cpu_clk_50M  in  1  clock
- cpu_rst_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  EX resolved a branch
- upd_pc_tag  in  TAG_W  branch PC index
- upd_target  in  ADDR_W  resolved target
- upd_taken  in  1  resolved direction
- upd_ready  out  1  update accepted this cycle when upd_valid is also high
- flush_req  in  1  single-cycle pulse: invalidate the whole BTB
- wr_req  out  1  BTB write strobe
- wr_clr  out  1  with wr_req: invalidate the entry (valid<=0, state<=WEAK_NOTJUMP)
- wr_pc_tag  out  TAG_W  BTB write index
- wr_predicted_pc  out  ADDR_W  BTB write target
- wr_jump_state  out  1  BTB write direction
- lookup_block  out  1  fetch must treat BTB output as not-taken
- sweep_busy  out  1  sweep in progress

Behaviour:
- Reset (asynchronous, active-low):
  - State = CLEAR, sweep counter = 0, FIFO empty.
  - wr_req, wr_clr, wr_pc_tag, wr_predicted_pc and wr_jump_state = 0.
  - lookup_block = 1, sweep_busy = 1.
- States: CLEAR, RUN.
- CLEAR:
  - Every cycle, registered outputs are wr_req=1, wr_clr=1, wr_pc_tag=counter, other data 0; then counter+1.
  - After issuing index 2^TAG_W-1, the counter wraps to 0 and the next state is RUN.
  - Sweep length is exactly 2^TAG_W cycles.
  - upd_ready=0 for the whole state.
  - flush_req in CLEAR restarts the counter at 0 on the next edge.
- RUN:
  - upd_ready = !full && !flush_req (combinational).
  - An update is enqueued when upd_valid && upd_ready.
  - If the FIFO is non-empty, the head is popped and driven on registered outputs the next cycle: wr_req=1, wr_clr=0, tag/target/taken from the entry.
  - Otherwise wr_req=0.
  - Latency: an update accepted at edge N into an empty FIFO gives wr_req high in cycle N+1. Enqueue and dequeue pass through the FIFO with no bypass.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Full: upd_ready=0. The producer may hold or drop the update; a dropped update only costs prediction accuracy.
- flush_req in RUN:
  - FIFO is discarded: pointers and count reset to 0.
  - Same-cycle upd_valid is not accepted.
  - Next state is CLEAR with counter=0.
  - A write already registered on the outputs in that cycle completes; the sweep overwrites it.
- lookup_block = (state==CLEAR) || flush_req.
- sweep_busy = (state==CLEAR).
- FIFO storage is not reset; only the pointers and count are.
- Width rules: the counter is TAG_W+1 bits, with the MSB marking terminal wrap. FIFO pointers are log2(FIFO_DEPTH) bits, count is log2(FIFO_DEPTH)+1 bits.
- Only one BTB write occurs per cycle; sweep and drain are mutually exclusive by state.

Optional Feature:
- Macro: BTB_UPD_PERF_EN.
- Defined: adds three outputs, each 16 bits and saturating at 0xFFFF, cleared by reset only, not by flush:
  - perf_upd_cnt: BTB update writes issued.
  - perf_drop_cnt: cycles with upd_valid && !upd_ready.
  - perf_flush_cnt: flush_req pulses.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- The shared defines file gains:
  - BTB_TAG_W, replacing the PC_ADDR_BTB width.
  - State encodings BTBU_CLEAR=1'b0 and BTBU_RUN=1'b1.
  - An update entry packing macro: {tag, target, taken}, TAG_W+ADDR_W+1 bits.
- One sub-module, btb_upd_fifo: synchronous FIFO with push, pop, flush, full, empty, count and an asynchronous pointer reset.
- The FSM, sweep counter and output registers stay in btb_update_ctrl.

Test Plan (TAG_W=4, FIFO_DEPTH=4 for simulation):
- Reset release → wr_req=wr_clr=1 for exactly 16 cycles with wr_pc_tag 0..15 in order. Then sweep_busy=0, lookup_block=0, wr_req=0.
- One update (tag 5, target 0x8000_0040, taken 1) accepted at edge N → cycle N+1 shows wr_req=1, wr_clr=0, tag 5, target 0x8000_0040, jump_state 1. Cycle N+2 shows wr_req=0.
- upd_valid held every cycle with distinct tags 1..6 → every update is accepted and each is written exactly once, in order.
- Force full (hold BTB drain off in a bench-only FIFO test) → upd_ready=0 at count 4. A push and pop in the same cycle at count 4 keeps the count at 4.
- Three updates queued, then flush_req → queued updates never appear on wr_*. The same-cycle upd_valid sees upd_ready=0. A 16-cycle clear sweep starts next cycle.
- flush_req at sweep index 9 → the next write index is 0 and 16 more clear cycles follow. cpu_rst_n low mid-sweep → outputs go to 0 asynchronously and the sweep restarts on release.
